// File: rtl/acc_prefix_sum.sv
// acc_prefix_sum
// In-place 32-bit prefix-sum accelerator for the MIPS data memory.
// A rising edge on accbypassA in IDLE launches a job that walks datasizeA
// words starting at startaddrA. Each word is replaced by the running sum of
// itself and every earlier word in the block. Completion is flagged by a
// one-cycle accdone pulse, and the final sum is held on result.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   accbypassA  start request (rising-edge sensitive)
//   startaddrA  word address of the first element
//   datasizeA   number of words to process (0..2^AW-1)
//   readdata    data-memory read data, combinational from addr
//   memwrite    data-memory write enable
//   addr        data-memory word address
//   writedata   data-memory write data
//   accdone     one-cycle completion pulse
//   busy        high while the job is in RUN
//   result      final running sum of the last completed job
module acc_prefix_sum #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accbypassA,
  input  logic [AW-1:0] startaddrA,
  input  logic [AW-1:0] datasizeA,
  input  logic [DW-1:0] readdata,
  output logic          memwrite,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] writedata,
  output logic          accdone,
  output logic          busy,
  output logic [DW-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          req_r;
  logic          start_s;
  logic [AW-1:0] cur_r;
  logic [AW-1:0] remaining_r;
  logic [DW-1:0] acc_r;
  logic [DW-1:0] result_r;
  logic [DW-1:0] sum_s;

  // Only a low-to-high transition of the request counts; a held level does not.
  assign start_s = accbypassA & ~req_r;
  assign sum_s   = acc_r + readdata;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          // A zero-length job skips RUN and just reports completion.
          if (datasizeA != {AW{1'b0}}) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (remaining_r == AW'(1)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory-port and status outputs, decoded from the registered state.
  always_comb begin
    memwrite  = 1'b0;
    writedata = {DW{1'b0}};
    addr      = cur_r;
    busy      = (state_r == RUN);
    accdone   = (state_r == DONE);
    if (state_r == RUN) begin
      memwrite  = 1'b1;
      writedata = sum_s;
    end else begin
      memwrite  = 1'b0;
      writedata = {DW{1'b0}};
    end
  end

  // Job datapath: request edge tracker, address walker, running sum, result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_r       <= 1'b0;
      cur_r       <= {AW{1'b0}};
      remaining_r <= {AW{1'b0}};
      acc_r       <= {DW{1'b0}};
      result_r    <= {DW{1'b0}};
    end else begin
      req_r <= accbypassA;
      case (state_r)
        IDLE: begin
          // Job parameters are captured only here; later input changes are ignored.
          if (start_s) begin
            cur_r       <= startaddrA;
            remaining_r <= datasizeA;
            acc_r       <= {DW{1'b0}};
          end else begin
            cur_r <= cur_r;
          end
        end
        RUN: begin
          acc_r       <= sum_s;
          cur_r       <= cur_r + AW'(1);
          remaining_r <= remaining_r - AW'(1);
        end
        DONE: begin
          result_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_acc_prefix_sum.sv
module tb_acc_prefix_sum;

  logic        clk;
  logic        reset;
  logic        accbypassA;
  logic [5:0]  startaddrA;
  logic [5:0]  datasizeA;
  logic [31:0] readdata;
  logic        memwrite;
  logic [5:0]  addr;
  logic [31:0] writedata;
  logic        accdone;
  logic        busy;
  logic [31:0] result;

  logic [31:0] mem [64];
  logic        poke_en;
  logic [5:0]  poke_a;
  logic [31:0] poke_d;

  int nchk;
  int nfail;
  int wr_cnt;
  int done_cnt;

  acc_prefix_sum #(.AW(6), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .accbypassA (accbypassA),
    .startaddrA (startaddrA),
    .datasizeA  (datasizeA),
    .readdata   (readdata),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .accdone    (accdone),
    .busy       (busy),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read data memory; writes from DUT or from bench preload.
  assign readdata = mem[addr];
  always @(posedge clk) begin
    if (memwrite) mem[addr] <= writedata;
    else if (poke_en) mem[poke_a] <= poke_d;
  end

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (memwrite) wr_cnt <= wr_cnt + 1;
    if (accdone) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Launch a job with a one-cycle request pulse and wait for accdone.
  task automatic run_job(input logic [5:0] sa, input logic [5:0] n, input bit chg,
                         output int lat, output int busyc, output logic [5:0] a1);
    @(negedge clk);
    startaddrA = sa; datasizeA = n; accbypassA = 1'b1;
    lat = -1; busyc = 0; a1 = 6'd0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      accbypassA = 1'b0;
      if (c == 1) a1 = addr;
      if (chg && c == 1) begin
        startaddrA = sa + 6'd7;
        datasizeA  = 6'd50;
      end
      if (busy) busyc++;
      if (accdone) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  int lat, busyc, w0, d0;
  logic [5:0] a1;

  initial begin
    nchk = 0; nfail = 0; wr_cnt = 0; done_cnt = 0;
    reset = 1'b1; accbypassA = 1'b0; startaddrA = 6'd0; datasizeA = 6'd0;
    poke_en = 1'b0; poke_a = 6'd0; poke_d = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_memwrite", {31'd0, memwrite}, 32'd0);
    check("rst_addr", {26'd0, addr}, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_accdone", {31'd0, accdone}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;

    // Basic job
    poke(6'd10, 32'd1); poke(6'd11, 32'd2); poke(6'd12, 32'd3); poke(6'd13, 32'd4);
    #1 w0 = wr_cnt; d0 = done_cnt;
    run_job(6'd10, 6'd4, 1'b0, lat, busyc, a1);
    check("basic_latency", lat, 32'd5);
    check("basic_busy", busyc, 32'd4);
    check("basic_first_addr", {26'd0, a1}, 32'd10);
    check("basic_m10", mem[10], 32'd1);
    check("basic_m11", mem[11], 32'd3);
    check("basic_m12", mem[12], 32'd6);
    check("basic_m13", mem[13], 32'd10);
    check("basic_result", result, 32'd10);
    check("basic_pulse_end", {31'd0, accdone}, 32'd0);
    #1;
    check("basic_writes", wr_cnt - w0, 32'd4);
    check("basic_done_cnt", done_cnt - d0, 32'd1);

    // Zero size
    w0 = wr_cnt;
    run_job(6'd5, 6'd0, 1'b0, lat, busyc, a1);
    check("zero_latency", lat, 32'd1);
    check("zero_busy", busyc, 32'd0);
    check("zero_result", result, 32'd0);
    #1;
    check("zero_writes", wr_cnt - w0, 32'd0);

    // Wrap and overflow
    poke(6'd62, 32'hFFFF_FFFF); poke(6'd63, 32'd1); poke(6'd0, 32'd5); poke(6'd1, 32'h0000_ABCD);
    run_job(6'd62, 6'd3, 1'b0, lat, busyc, a1);
    check("wrap_latency", lat, 32'd4);
    check("wrap_first_addr", {26'd0, a1}, 32'd62);
    check("wrap_m62", mem[62], 32'hFFFF_FFFF);
    check("wrap_m63", mem[63], 32'd0);
    check("wrap_m0", mem[0], 32'd5);
    check("wrap_m1", mem[1], 32'h0000_ABCD);
    check("wrap_result", result, 32'd5);

    // Ignored request: held high, with a second rising edge during RUN
    poke(6'd20, 32'd7); poke(6'd21, 32'd8); poke(6'd22, 32'd9);
    #1 d0 = done_cnt;
    @(negedge clk);
    startaddrA = 6'd20; datasizeA = 6'd3; accbypassA = 1'b1;
    lat = -1; busyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) accbypassA = 1'b0;
      if (c == 2) accbypassA = 1'b1;
      if (busy) busyc++;
      if (accdone && lat < 0) lat = c;
    end
    #1;
    check("ign_latency", lat, 32'd4);
    check("ign_done_cnt", done_cnt - d0, 32'd1);
    check("ign_busy", busyc, 32'd3);
    check("ign_m20", mem[20], 32'd7);
    check("ign_m22", mem[22], 32'd24);
    @(negedge clk);
    accbypassA = 1'b0;

    // Input change mid-job (also a fresh rising edge after the held request)
    poke(6'd30, 32'd100); poke(6'd31, 32'd200); poke(6'd32, 32'd55);
    poke(6'd37, 32'd77);
    #1 w0 = wr_cnt;
    run_job(6'd30, 6'd2, 1'b1, lat, busyc, a1);
    check("chg_latency", lat, 32'd3);
    check("chg_m30", mem[30], 32'd100);
    check("chg_m31", mem[31], 32'd300);
    check("chg_m32", mem[32], 32'd55);
    check("chg_m37", mem[37], 32'd77);
    check("chg_result", result, 32'd300);
    #1;
    check("chg_writes", wr_cnt - w0, 32'd2);

    // Reset mid-job after two of five words are written
    for (int i = 40; i < 45; i++) poke(6'(i), 32'd1);
    #1 d0 = done_cnt;
    @(negedge clk);
    startaddrA = 6'd40; datasizeA = 6'd5; accbypassA = 1'b1;
    @(negedge clk);
    accbypassA = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_memwrite", {31'd0, memwrite}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {26'd0, addr}, 32'd0);
    check("mid_rst_writedata", writedata, 32'd0);
    check("mid_rst_accdone", {31'd0, accdone}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mid_rst_done_cnt", done_cnt - d0, 32'd0);
    check("mid_rst_m40", mem[40], 32'd1);
    check("mid_rst_m41", mem[41], 32'd2);
    check("mid_rst_m42", mem[42], 32'd1);
    check("mid_rst_m44", mem[44], 32'd1);

    // Normal job after reset
    poke(6'd50, 32'd3); poke(6'd51, 32'd4);
    run_job(6'd50, 6'd2, 1'b0, lat, busyc, a1);
    check("post_latency", lat, 32'd3);
    check("post_m51", mem[51], 32'd7);
    check("post_result", result, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
